// File: rtl/div16_seq.sv
// Sequential IEEE 754 half-precision divider, result = a / b, restoring, one quotient bit per clock.
// Latency: 14 edges for normal operands (load, 12 divide, normalise), 1 edge for special operands.
// Backpressure: start is only honoured in IDLE; a start while busy or during done is dropped.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   start, a, b        request and operands, sampled together in IDLE
//   busy               division in progress
//   done               one-cycle pulse; result/flags are valid from this cycle and held until the next done
//   result, flags      quotient and {overflow, underflow, div_by_zero}
module div16_seq #(
    parameter int tam  = 16,
    parameter int BIAS = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [tam-1:0] a,
    input  logic [tam-1:0] b,
    output logic           busy,
    output logic           done,
    output logic [tam-1:0] result,
    output logic [2:0]     flags
);

    typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

    state_t state, state_nxt;

    logic        sign;
    logic [4:0]  ea, eb;
    logic [11:0] rem;
    logic [10:0] dvs;
    logic [11:0] q;
    logic [3:0]  cnt;

    // Operand classification straight from the inputs, used in IDLE only.
    logic a_zero, a_inf, b_zero, b_inf, in_sign, special;
    logic [15:0] spec_res;
    logic [2:0]  spec_flags;

    assign a_zero  = (a[14:10] == 5'h00);
    assign a_inf   = (a[14:10] == 5'h1F);
    assign b_zero  = (b[14:10] == 5'h00);
    assign b_inf   = (b[14:10] == 5'h1F);
    assign in_sign = a[15] ^ b[15];
    assign special = a_zero | a_inf | b_zero | b_inf;

    always_comb begin
        spec_res   = {in_sign, 15'h0000};
        spec_flags = 3'b000;
        if (a_inf && b_inf) begin
            spec_res = 16'h7E00;
        end else if (a_zero && b_zero) begin
            spec_res   = 16'h7E00;
            spec_flags = 3'b001;
        end else if (b_zero) begin
            spec_res   = {in_sign, 5'h1F, 10'h000};
            spec_flags = 3'b001;
        end else if (a_inf) begin
            spec_res = {in_sign, 5'h1F, 10'h000};
        end
    end

    // Restoring step: rem never reaches 2*dvs, so the subtracted value fits
    // in 11 bits and the left shift loses nothing.
    logic        ge;
    logic [11:0] rem_sub;

    assign ge      = (rem >= {1'b0, dvs});
    assign rem_sub = ge ? (rem - {1'b0, dvs}) : rem;

    // Normalisation: q lies in [2^10, 2^12), so at most one position of shift.
    logic signed [6:0] e_calc;
    logic [9:0]        mant;
    logic [15:0]       norm_res;
    logic [2:0]        norm_flags;

    always_comb begin
        mant       = q[11] ? q[10:1] : q[9:0];
        e_calc     = {2'b00, ea} - {2'b00, eb} + 7'(BIAS) - {6'd0, ~q[11]};
        norm_res   = {sign, e_calc[4:0], mant};
        norm_flags = 3'b000;
        if (e_calc >= 7'sd31) begin
            norm_res   = {sign, 5'h1F, 10'h000};
            norm_flags = 3'b100;
        end else if (e_calc <= 7'sd0) begin
            norm_res   = {sign, 15'h0000};
            norm_flags = 3'b010;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = special ? DONE : DIVIDE;
                end
            end
            DIVIDE: begin
                busy = 1'b1;
                if (cnt == 4'd0) begin
                    state_nxt = NORM;
                end
            end
            NORM: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign   <= 1'b0;
            ea     <= 5'd0;
            eb     <= 5'd0;
            rem    <= 12'd0;
            dvs    <= 11'd0;
            q      <= 12'd0;
            cnt    <= 4'd0;
            result <= 16'h0000;
            flags  <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign <= in_sign;
                        ea   <= a[14:10];
                        eb   <= b[14:10];
                        if (special) begin
                            result <= spec_res;
                            flags  <= spec_flags;
                        end else begin
                            rem <= {1'b0, 1'b1, a[9:0]};
                            dvs <= {1'b1, b[9:0]};
                            q   <= 12'd0;
                            cnt <= 4'd11;
                        end
                    end
                end
                DIVIDE: begin
                    q   <= {q[10:0], ge};
                    rem <= {rem_sub[10:0], 1'b0};
                    cnt <= cnt - 4'd1;
                end
                NORM: begin
                    result <= norm_res;
                    flags  <= norm_flags;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div16_seq.sv
// Directed bench for div16_seq: expected results queued at issue, popped and compared on done.
// Drives and samples on the falling edge; latency counted in rising edges from the sampling edge.
// Start is held for one cycle; injected starts during a division must be dropped.
module tb_div16_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [2:0]  flags;

    int total = 0;
    int bad   = 0;

    logic [18:0] exp_q[$];

    div16_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flags  (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Issue one division; inj>0 pulses a foreign start so that it is sampled at edge inj.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_op,
                          input logic [15:0] er, input logic [2:0] ef, input int elat, input int inj);
        int          lat;
        int          bcnt;
        logic [18:0] expv;
        exp_q.push_back({er, ef});
        @(negedge clk);
        a     = ta;
        b     = tb_op;
        start = 1'b1;
        @(posedge clk);
        lat  = 1;
        bcnt = 0;
        @(negedge clk);
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            if (lat == inj - 1) begin
                start = 1'b1;
                a     = 16'h4600;
                b     = 16'h4000;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
            expv = 19'd0;
        end else begin
            expv = exp_q.pop_front();
        end
        chk({tag, "_latency"}, 32'(lat), 32'(elat));
        chk({tag, "_result"}, {16'd0, result}, {16'd0, expv[18:3]});
        chk({tag, "_flags"}, {29'd0, flags}, {29'd0, expv[2:0]});
        chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(elat - 1));
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk({tag, "_done_width"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int dseen;
        rst_n = 1'b0;
        start = 1'b0;
        a     = 16'h0000;
        b     = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", {16'd0, result}, 32'h0000);
        chk("reset_flags", {29'd0, flags}, 32'd0);
        rst_n = 1'b1;

        run_op("one_by_one",  16'h3C00, 16'h3C00, 16'h3C00, 3'b000, 14, 0);
        run_op("six_by_two",  16'h4600, 16'h4000, 16'h4200, 3'b000, 14, 0);
        run_op("neg2_by_half",16'hC000, 16'h3800, 16'hC400, 3'b000, 14, 0);
        run_op("one_by_three",16'h3C00, 16'h4200, 16'h3555, 3'b000, 14, 0);
        run_op("div_zero",    16'h3C00, 16'h0000, 16'h7C00, 3'b001, 1, 0);
        run_op("zero_num",    16'h0000, 16'h4000, 16'h0000, 3'b000, 1, 0);
        run_op("inf_inf",     16'h7C00, 16'h7C00, 16'h7E00, 3'b000, 1, 0);
        run_op("zero_zero",   16'h0000, 16'h0000, 16'h7E00, 3'b001, 1, 0);
        run_op("ninf_zero",   16'hFC00, 16'h0000, 16'hFC00, 3'b001, 1, 0);
        run_op("inf_num",     16'h7C00, 16'hC000, 16'hFC00, 3'b000, 1, 0);
        run_op("num_ninf",    16'h4000, 16'hFC00, 16'h8000, 3'b000, 1, 0);
        run_op("overflow",    16'h7800, 16'h1400, 16'h7C00, 3'b100, 14, 0);
        run_op("neg_overflow",16'hF800, 16'h1400, 16'hFC00, 3'b100, 14, 0);
        run_op("underflow",   16'h0400, 16'h7800, 16'h0000, 3'b010, 14, 0);

        // Start sampled at edge 5 of a running division must be dropped.
        run_op("inject", 16'h3C00, 16'h3C00, 16'h3C00, 3'b000, 14, 5);
        dseen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) dseen++;
        end
        chk("inject_no_extra_done", 32'(dseen), 32'd0);

        // Reset in the middle of a division aborts it silently.
        @(negedge clk);
        a     = 16'h4600;
        b     = 16'h4000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", {16'd0, result}, 32'h0000);
        chk("abort_flags", {29'd0, flags}, 32'd0);
        dseen = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (k == 3) rst_n = 1'b1;
            if (done === 1'b1) dseen++;
        end
        chk("abort_no_done", 32'(dseen), 32'd0);

        run_op("after_reset", 16'h4600, 16'h4000, 16'h4200, 3'b000, 14, 0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
